// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared encodings for the MEM-stage data-memory interface:
//                RV32I load/store funct3 values, responder state encoding and
//                helpers that classify an access as misaligned or illegal.
//                Used by the responder, the MEM stage and hazard logic.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // RV32I load/store size/sign field. Stores only use B/H/W.
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } f3_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Half accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lsbs);
        logic r;
        r = 1'b0;
        case (funct3)
            F3_H, F3_HU: r = addr_lsbs[0];
            F3_W:        r = (addr_lsbs != 2'b00);
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

    // Unsigned variants exist only for loads.
    function automatic logic is_illegal_f3(input logic [2:0] funct3,
                                           input logic       is_store);
        logic r;
        r = 1'b1;
        case (funct3)
            F3_B, F3_H, F3_W: r = 1'b0;
            F3_BU, F3_HU:     r = is_store;
            default:          r = 1'b1;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Combinational lane steering between a 32-bit memory word and
//                the right-aligned register view.
//                Store path: byte enables + write data replicated into lanes.
//                Load path : lane select + sign/zero extension.
//  Ports       : i_funct3      access size/sign
//                i_addr_lsb    byte offset within the word
//                i_store_data  right-aligned store data
//                i_load_word   word read from the array
//                o_byte_en     lanes to write (stores)
//                o_store_data  store data placed in its lanes
//                o_load_data   extended load result
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lsb,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_store_data,
    output logic [31:0] o_load_data
);

    logic [31:0] w_byte_shifted;
    logic [31:0] w_half_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Half accesses are even-aligned, so only addr[1] picks the half.
    assign w_byte_shifted = i_load_word >> {i_addr_lsb, 3'b000};
    assign w_half_shifted = i_load_word >> {i_addr_lsb[1], 4'b0000};
    assign w_byte         = w_byte_shifted[7:0];
    assign w_half         = w_half_shifted[15:0];

    always_comb begin
        o_byte_en    = 4'b0000;
        o_store_data = i_store_data;
        o_load_data  = 32'h0;
        case (i_funct3)
            F3_B: begin
                o_byte_en    = 4'b0001 << i_addr_lsb;
                o_store_data = {4{i_store_data[7:0]}};
                o_load_data  = {{24{w_byte[7]}}, w_byte};
            end
            F3_H: begin
                o_byte_en    = 4'b0011 << {i_addr_lsb[1], 1'b0};
                o_store_data = {2{i_store_data[15:0]}};
                o_load_data  = {{16{w_half[15]}}, w_half};
            end
            F3_W: begin
                o_byte_en    = 4'b1111;
                o_store_data = i_store_data;
                o_load_data  = i_load_word;
            end
            F3_BU:   o_load_data = {24'h0, w_byte};
            F3_HU:   o_load_data = {16'h0, w_half};
            default: o_load_data = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Fixed-latency data-memory responder for the MEM stage.
//                Accepts one load/store, holds the pipeline with Stall for
//                LATENCY cycles, then pulses RespValid with registered,
//                extended load data and an access-fault flag.
//  Ports       : clk, rst      clock, synchronous active-high reset
//                ReqValid      request present
//                MemWrite      1 = store, 0 = load
//                funct3        size/sign
//                A, WD         byte address, right-aligned store data
//                RD            load data (registered)
//                RespValid     one-cycle completion pulse
//                AccessFault   misaligned / illegal funct3, with RespValid
//                Stall         hold request stable
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ReqValid,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  RespValid,
    output logic                  AccessFault,
    output logic                  Stall
);

    localparam int              c_CNT_W  = 4;
    localparam int              c_WORDS  = 2 ** (ADDR_WIDTH - 2);
    localparam logic [c_CNT_W-1:0] c_LAT_M1 = c_CNT_W'(LATENCY - 1);

    state_e                  r_state;
    state_e                  w_next;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_CNT_W-1:0]      w_cnt_next;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wd;
    logic [2:0]              r_f3;
    logic                    r_we;
    logic                    r_fault;

    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wd;
    logic [2:0]              w_f3;
    logic                    w_we;
    logic                    w_fault;
    logic                    w_commit;
    logic [ADDR_WIDTH-3:0]   w_idx;
    logic [3:0]              w_be;
    logic [DATA_WIDTH-1:0]   w_st_data;
    logic [DATA_WIDTH-1:0]   w_ld_data;
    logic                    w_unused_addr_hi;

    logic [DATA_WIDTH-1:0]   r_mem [0:c_WORDS-1];

    // Address bits above ADDR_WIDTH alias onto the decoded range.
    assign w_unused_addr_hi = ^A[DATA_WIDTH-1:ADDR_WIDTH];

    // With LATENCY=1 the commit edge is the acceptance edge, so the live
    // request is used in IDLE; otherwise the captured copy.
    assign w_addr  = (r_state == S_IDLE) ? A[ADDR_WIDTH-1:0] : r_addr;
    assign w_wd    = (r_state == S_IDLE) ? WD       : r_wd;
    assign w_f3    = (r_state == S_IDLE) ? funct3   : r_f3;
    assign w_we    = (r_state == S_IDLE) ? MemWrite : r_we;

    assign w_fault  = is_illegal_f3(w_f3, w_we) | is_misaligned(w_f3, w_addr[1:0]);
    assign w_commit = (w_next == S_RESP) && (r_state != S_RESP);
    assign w_idx    = w_addr[ADDR_WIDTH-1:2];

    dmem_lane_align u_align (
        .i_funct3     (w_f3),
        .i_addr_lsb   (w_addr[1:0]),
        .i_store_data (w_wd),
        .i_load_word  (r_mem[w_idx]),
        .o_byte_en    (w_be),
        .o_store_data (w_st_data),
        .o_load_data  (w_ld_data)
    );

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        Stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ReqValid) begin
                    Stall      = 1'b1;
                    w_cnt_next = c_LAT_M1;
                    w_next     = (LATENCY == 1) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                Stall = 1'b1;
                if (r_cnt <= 1) begin
                    w_next     = S_RESP;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wd    <= '0;
            r_f3    <= '0;
            r_we    <= 1'b0;
            r_fault <= 1'b0;
            RD      <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_IDLE && ReqValid) begin
                r_addr <= A[ADDR_WIDTH-1:0];
                r_wd   <= WD;
                r_f3   <= funct3;
                r_we   <= MemWrite;
            end
            if (w_commit) begin
                r_fault <= w_fault;
                if (w_fault) begin
                    RD <= '0;
                end else if (!w_we) begin
                    RD <= w_ld_data;
                end
            end
        end
    end

    // Array is not reset; a reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_we && !w_fault) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][k*8 +: 8] <= w_st_data[k*8 +: 8];
                end
            end
        end
    end

    assign RespValid   = (r_state == S_RESP);
    assign AccessFault = (r_state == S_RESP) && r_fault;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. A LATENCY=2 instance
//                runs directed and random loads/stores against a byte-level
//                reference memory; a LATENCY=1 instance runs back-to-back
//                requests.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [2:0]  f3;
    logic [31:0] a, wd, rd;
    logic        rv, af, st;

    logic        d1_req, d1_we;
    logic [2:0]  d1_f3;
    logic [31:0] d1_a, d1_wd, d1_rd;
    logic        d1_rv, d1_af, d1_st;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .ReqValid(req), .MemWrite(we), .funct3(f3),
        .A(a), .WD(wd), .RD(rd), .RespValid(rv), .AccessFault(af), .Stall(st)
    );

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .ReqValid(d1_req), .MemWrite(d1_we), .funct3(d1_f3),
        .A(d1_a), .WD(d1_wd), .RD(d1_rd), .RespValid(d1_rv), .AccessFault(d1_af),
        .Stall(d1_st)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0]  ref_mem [int];
    logic [31:0] exp_rd = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic int key(input logic [31:0] addr);
        return int'(addr & 32'h1FFFF);
    endfunction

    function automatic logic [7:0] rb(input logic [31:0] addr);
        return ref_mem.exists(key(addr)) ? ref_mem[key(addr)] : 8'h00;
    endfunction

    // Access size in bytes, 0 if the funct3 is not legal for this direction.
    function automatic int acc_size(input logic w, input logic [2:0] f);
        case (f)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            3'd4: return w ? 0 : 1;
            3'd5: return w ? 0 : 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic model_fault(input logic w, input logic [2:0] f, input logic [31:0] addr);
        int sz;
        sz = acc_size(w, f);
        if (sz == 0) return 1'b1;
        return (int'(addr[1:0]) % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] addr);
        logic [7:0]  b;
        logic [15:0] h;
        b = rb(addr);
        h = {rb(addr + 1), rb(addr)};
        case (f)
            3'd0: return {{24{b[7]}}, b};
            3'd4: return {24'h0, b};
            3'd1: return {{16{h[15]}}, h};
            3'd5: return {16'h0, h};
            default: return {rb(addr + 3), rb(addr + 2), rb(addr + 1), rb(addr)};
        endcase
    endfunction

    task automatic model_store(input logic [2:0] f, input logic [31:0] addr, input logic [31:0] data);
        for (int i = 0; i < acc_size(1'b1, f); i++) ref_mem[key(addr + i)] = data[8*i +: 8];
    endtask

    // One complete request on the LATENCY=2 instance, checked against the model.
    task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] addr,
                          input logic [31:0] data, input string tag);
        int n;
        logic flt;
        logic [31:0] er;
        flt = model_fault(w, f, addr);
        if (flt)     er = 32'h0;
        else if (!w) er = model_load(f, addr);
        else         er = exp_rd;
        @(negedge clk);
        req = 1'b1; we = w; f3 = f; a = addr; wd = data;
        #1;
        n = 0;
        while (st && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, " stall_cycles"}, 32'(n), 32'(LAT));
        chk({tag, " RespValid"}, {31'h0, rv}, 32'h1);
        chk({tag, " AccessFault"}, {31'h0, af}, {31'h0, flt});
        chk({tag, " RD"}, rd, er);
        if (!flt && w) model_store(f, addr, data);
        exp_rd = er;
        req = 1'b0;
        @(negedge clk); #1;
        chk({tag, " pulse_end"}, {30'h0, rv, af}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d1_data [4];
        logic [31:0] d1_exp;
        logic [31:0] ra;

        rst = 1'b1; req = 1'b0; we = 1'b0; f3 = 3'd0; a = '0; wd = '0;
        d1_req = 1'b0; d1_we = 1'b0; d1_f3 = 3'd0; d1_a = '0; d1_wd = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset RD", rd, 32'h0);
        chk("reset RespValid/AccessFault/Stall", {29'h0, rv, af, st}, 32'h0);
        chk("reset d1 outputs", {29'h0, d1_rv, d1_af, d1_st}, 32'h0);

        // Directed sequence
        do_req(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, "SW 0x100");
        do_req(1'b0, 3'd2, 32'h100, 32'h0, "LW 0x100");
        do_req(1'b0, 3'd0, 32'h103, 32'h0, "LB 0x103");
        do_req(1'b0, 3'd4, 32'h103, 32'h0, "LBU 0x103");
        do_req(1'b0, 3'd1, 32'h102, 32'h0, "LH 0x102");
        do_req(1'b1, 3'd0, 32'h101, 32'hFFFFFF12, "SB 0x101");
        do_req(1'b0, 3'd2, 32'h100, 32'h0, "LW after SB");
        do_req(1'b0, 3'd2, 32'h102, 32'h0, "LW misaligned");
        do_req(1'b1, 3'd1, 32'h101, 32'h5555AAAA, "SH misaligned");
        do_req(1'b0, 3'd2, 32'h100, 32'h0, "LW after faults");
        do_req(1'b0, 3'd3, 32'h100, 32'h0, "funct3 011");
        do_req(1'b1, 3'd4, 32'h100, 32'h0, "store funct3 100");
        do_req(1'b0, 3'd5, 32'h102, 32'h0, "LHU 0x102");
        do_req(1'b0, 3'd2, 32'h00020100, 32'h0, "LW wrap 0x20100");
        do_req(1'b0, 3'd2, 32'hFFFE0100, 32'h0, "LW upper bits");

        // Reset during BUSY drops the pending store
        do_req(1'b1, 3'd2, 32'h200, 32'hCAFEF00D, "SW 0x200");
        @(negedge clk);
        req = 1'b1; we = 1'b1; f3 = 3'd2; a = 32'h200; wd = 32'h1;
        #1;
        chk("rst-test accept Stall", {31'h0, st}, 32'h1);
        @(negedge clk); #1;
        chk("rst-test busy Stall", {31'h0, st}, 32'h1);
        rst = 1'b1; req = 1'b0;
        @(negedge clk); #1;
        chk("rst-test after reset", {29'h0, rv, af, st}, 32'h0);
        rst = 1'b0;
        exp_rd = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("rst-test no RespValid", {31'h0, rv}, 32'h0);
        end
        do_req(1'b0, 3'd2, 32'h200, 32'h0, "LW 0x200 after reset");

        // Random traffic inside a preloaded window
        for (int i = 0; i < 16; i++) do_req(1'b1, 3'd2, 32'h300 + 32'(4 * i), $urandom, "rand init");
        for (int i = 0; i < 60; i++) begin
            ra = 32'h300 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 7)) << 17);
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, "rand");
        end

        // LATENCY=1 instance, ReqValid held high across back-to-back requests
        for (int k = 0; k < 4; k++) d1_data[k] = $urandom;
        d1_exp = 32'h0;
        @(negedge clk);
        d1_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d1_we = (i < 4); d1_f3 = 3'd2; d1_a = 32'h40 + 32'(4 * (i % 4)); d1_wd = d1_data[i % 4];
            #1;
            chk("L1 accept Stall/RespValid", {30'h0, d1_st, d1_rv}, 32'h2);
            @(negedge clk); #1;
            if (i >= 4) d1_exp = d1_data[i % 4];
            chk("L1 resp Stall/RespValid/Fault", {29'h0, d1_st, d1_rv, d1_af}, 32'h2);
            chk("L1 resp RD", d1_rd, d1_exp);
            @(negedge clk);
        end
        d1_req = 1'b0;
        #1;
        chk("L1 idle after burst", {30'h0, d1_st, d1_rv}, 32'h0);
        @(negedge clk); #1;
        chk("L1 no extra RespValid", {31'h0, d1_rv}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
